armleocpu_cache_arbiter: RTL and testbench

- Shares one cache command port between two requesters: port 0 is instruction fetch, port 1 is the execute/memory unit.
- Forwards the granted requester's command, address and store data to the cache combinationally.
- Locks the grant until the cache returns c_done, then routes done, response and load data back to the owner only.
- Sits between the fetch and execute units and the single cache instance in the core top level.

---
 rtl/armleocpu_cache_arbiter_pkg.sv | 13 +
 rtl/armleocpu_cache_arbiter_if.sv | 35 +++
 rtl/armleocpu_cache_arbiter_timeout.sv | 31 +++
 rtl/armleocpu_cache_arbiter.sv | 72 +++++++
 tb/tb_armleocpu_cache_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/armleocpu_cache_arbiter_pkg.sv
// armleocpu_cache_arbiter_pkg: cache command/response encodings shared by the arbiter, fetch, execute and cache
package armleocpu_cache_arbiter_pkg;
  localparam int CACHE_CMD_W = 4;
  localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_NONE      = 4'd0;
  localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_EXECUTE   = 4'd1;
  localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_LOAD      = 4'd2;
  localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_STORE     = 4'd3;
  localparam logic [CACHE_CMD_W-1:0] CACHE_CMD_FLUSH_ALL = 4'd4;
  localparam logic [3:0] CACHE_RESPONSE_DONE          = 4'd1;
  localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED   = 4'd2;
  localparam logic [3:0] CACHE_RESPONSE_PAGEFAULT     = 4'd3;
  localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT   = 4'd4;
endpackage

// File: rtl/armleocpu_cache_arbiter_if.sv
// armleocpu_cache_arbiter_if: fetch, execute and cache command ports bundled around the arbiter
interface armleocpu_cache_arbiter_if;
  import armleocpu_cache_arbiter_pkg::*;
  logic [CACHE_CMD_W-1:0] f_cmd;
  logic [31:0]            f_address;
  logic                   f_done;
  logic [3:0]             f_response;
  logic [31:0]            f_load_data;
  logic [CACHE_CMD_W-1:0] m_cmd;
  logic [31:0]            m_address;
  logic [31:0]            m_store_data;
  logic [3:0]             m_store_byteenable;
  logic                   m_done;
  logic [3:0]             m_response;
  logic [31:0]            m_load_data;
  logic [CACHE_CMD_W-1:0] c_cmd;
  logic [31:0]            c_address;
  logic [31:0]            c_store_data;
  logic [3:0]             c_store_byteenable;
  logic                   c_done;
  logic [3:0]             c_response;
  logic [31:0]            c_load_data;
  modport slave (
    input  f_cmd, f_address, m_cmd, m_address, m_store_data, m_store_byteenable,
           c_done, c_response, c_load_data,
    output f_done, f_response, f_load_data, m_done, m_response, m_load_data,
           c_cmd, c_address, c_store_data, c_store_byteenable
  );
  modport master (
    output f_cmd, f_address, m_cmd, m_address, m_store_data, m_store_byteenable,
           c_done, c_response, c_load_data,
    input  f_done, f_response, f_load_data, m_done, m_response, m_load_data,
           c_cmd, c_address, c_store_data, c_store_byteenable
  );
endinterface

// File: rtl/armleocpu_cache_arbiter_timeout.sv
// armleocpu_cache_arbiter_timeout: saturating outstanding-cycle counter with a sticky error flag
module armleocpu_cache_arbiter_timeout #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_WIDTH  = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic err_o
);
  localparam logic [TIMEOUT_WIDTH-1:0] LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [TIMEOUT_WIDTH-1:0] MAX   = '1;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic err_q, err_d;
  always_comb begin
    cnt_d = clear_i ? '0 : (inc_i && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
    // a zero limit disables the check entirely
    err_d = err_q || ((TIMEOUT_CYCLES != 0) && inc_i && !clear_i && cnt_q == LIMIT - 1'b1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign err_o = err_q;
endmodule

// File: rtl/armleocpu_cache_arbiter.sv
// armleocpu_cache_arbiter: round-robin share of one cache command port between fetch (0) and execute (1)
module armleocpu_cache_arbiter
  import armleocpu_cache_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMEOUT_WIDTH  = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  armleocpu_cache_arbiter_if.slave bus,
  output logic                     busy_o,
  output logic                     owner_o,
  output logic                     timeout_err_o
);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e state_q, state_d;
  logic owner_q, owner_d, prio_q, prio_d;
  logic req0, req1, in_busy, done_ok, hold, grant, winner, sel, drive;
  always_comb begin
    req0    = bus.f_cmd != CACHE_CMD_NONE;
    req1    = bus.m_cmd != CACHE_CMD_NONE;
    in_busy = state_q == BUSY;
    done_ok = in_busy && bus.c_done;
    hold    = in_busy && !bus.c_done;
    // the done cycle doubles as an arbitration cycle, so back-to-back commands issue with no bubble
    grant   = !hold && (req0 || req1);
    winner  = (req0 && req1) ? prio_q : req1;
    sel     = grant ? winner : owner_q;
    drive   = rst_n && (grant || hold);
    bus.c_cmd              = !drive ? CACHE_CMD_NONE : sel ? bus.m_cmd : bus.f_cmd;
    bus.c_address          = !drive ? '0 : sel ? bus.m_address : bus.f_address;
    bus.c_store_data       = (drive && sel) ? bus.m_store_data : '0;
    bus.c_store_byteenable = (drive && sel) ? bus.m_store_byteenable : '0;
    bus.f_done             = done_ok && !owner_q;
    bus.m_done             = done_ok && owner_q;
    bus.f_response         = (done_ok && !owner_q) ? bus.c_response : '0;
    bus.f_load_data        = (done_ok && !owner_q) ? bus.c_load_data : '0;
    bus.m_response         = (done_ok && owner_q) ? bus.c_response : '0;
    bus.m_load_data        = (done_ok && owner_q) ? bus.c_load_data : '0;
    busy_o  = rst_n && (in_busy || req0 || req1);
    owner_o = sel;
    state_d = (grant || hold) ? BUSY : IDLE;
    owner_d = sel;
    prio_d  = grant ? !winner : prio_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
    end
  end
  armleocpu_cache_arbiter_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(!hold),
    .inc_i  (hold),
    .err_o  (timeout_err_o)
  );
`ifdef FORMAL_RULES
  a_cmd_stable: assert property (@(posedge clk) disable iff (!rst_n) hold |=> $stable(bus.c_cmd));
  a_one_done:   assert property (@(posedge clk) disable iff (!rst_n) !(bus.f_done && bus.m_done));
  a_done_busy:  assert property (@(posedge clk) disable iff (!rst_n) (bus.f_done || bus.m_done) |-> in_busy);
`endif
endmodule

// File: tb/tb_armleocpu_cache_arbiter.sv
// tb_armleocpu_cache_arbiter: random requesters and cache model, scoreboarded done/response plus per-cycle c_* checks
module tb_armleocpu_cache_arbiter;
  import armleocpu_cache_arbiter_pkg::*;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy, owner, terr;
  always #5 clk = ~clk;

  armleocpu_cache_arbiter_if bus();
  armleocpu_cache_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy_o(busy), .owner_o(owner), .timeout_err_o(terr)
  );

  typedef struct packed {logic port; logic [3:0] resp; logic [31:0] data;} done_t;
  done_t exp_q[$];
  int compared = 0, mismatched = 0;

  logic [3:0]  cmd [2];
  logic [31:0] addr [2];
  logic [31:0] sd;
  logic [3:0]  be;
  bit          dir_v [2];
  logic [3:0]  dir_cmd [2];
  logic [31:0] dir_addr [2];
  logic [31:0] dir_sd;
  logic [3:0]  dir_be;
  int issue_pct = 0, lat_hi = 4, lat_fix = -1;
  bit fd_v = 0;
  logic [3:0]  fd_resp;
  logic [31:0] fd_data;

  // reference model: which port holds the cache, who wins the next tie, remaining latency
  int cur = -1, lat = 0, tcnt = 0;
  bit pref = 0, last_owner = 0, err_m = 0;
  logic [3:0]  e_cmd, e_be;
  logic [31:0] e_addr, e_sd;
  bit e_busy, e_owner, checking = 0, contend = 0, have_prev = 0, prev_port = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_ports();
    bus.f_cmd = cmd[0];
    bus.f_address = addr[0];
    bus.m_cmd = cmd[1];
    bus.m_address = addr[1];
    bus.m_store_data = sd;
    bus.m_store_byteenable = be;
  endtask

  task automatic cycle();
    bit cd, r0, r1, free;
    int win, sel;
    @(posedge clk); #1;
    cd = cur >= 0 && lat == 0;
    bus.c_done = cd;
    bus.c_response = fd_v ? fd_resp : 4'($urandom);
    bus.c_load_data = fd_v ? fd_data : $urandom;
    if (cd) exp_q.push_back(done_t'{port: cur[0], resp: bus.c_response, data: bus.c_load_data});
    for (int p = 0; p < 2; p++) begin
      if (cd && cur == p) cmd[p] = CACHE_CMD_NONE;
      if (cmd[p] == CACHE_CMD_NONE) begin
        addr[p] = $urandom;
        if (p == 1) begin sd = $urandom; be = 4'($urandom); end
        if (dir_v[p]) begin
          cmd[p] = dir_cmd[p];
          addr[p] = dir_addr[p];
          if (p == 1) begin sd = dir_sd; be = dir_be; end
          dir_v[p] = 0;
        end else if (int'($urandom_range(99)) < issue_pct) cmd[p] = 4'($urandom_range(1, 4));
      end
    end
    drive_ports();
    r0 = cmd[0] != CACHE_CMD_NONE;
    r1 = cmd[1] != CACHE_CMD_NONE;
    free = cur < 0 || cd;
    win = !free ? -1 : (r0 && r1) ? int'(pref) : r1 ? 1 : r0 ? 0 : -1;
    sel = free ? win : cur;
    e_cmd = sel < 0 ? CACHE_CMD_NONE : cmd[sel];
    e_addr = sel < 0 ? 32'h0 : addr[sel];
    e_sd = sel == 1 ? sd : 32'h0;
    e_be = sel == 1 ? be : 4'h0;
    e_busy = cur >= 0 || r0 || r1;
    e_owner = (free && win >= 0) ? win[0] : last_owner;
    checking = 1;
    @(negedge clk); #1;
    if (cur >= 0 && !cd) begin
      lat--;
      tcnt++;
      if (tcnt == TO) err_m = 1;
    end
    if (free) begin
      cur = win;
      if (win >= 0) begin
        pref = !win[0];
        last_owner = win[0];
        lat = lat_fix >= 0 ? lat_fix : int'($urandom_range(lat_hi));
        tcnt = 0;
      end
    end
  endtask

  task automatic do_reset();
    checking = 0;
    rst_n = 0;
    cur = -1; pref = 0; last_owner = 0; err_m = 0; contend = 0;
    exp_q.delete();
    cmd[0] = CACHE_CMD_NONE;
    cmd[1] = CACHE_CMD_NONE;
    drive_ports();
    bus.c_done = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && (cur >= 0 || cmd[0] != CACHE_CMD_NONE || cmd[1] != CACHE_CMD_NONE); i++) cycle();
    chk("drain_bound", cur < 0 && cmd[0] == CACHE_CMD_NONE && cmd[1] == CACHE_CMD_NONE, 1);
  endtask

  always @(negedge clk) if (checking) begin
    chk("c_cmd", bus.c_cmd, e_cmd);
    chk("c_address", bus.c_address, e_addr);
    chk("c_store_data", bus.c_store_data, e_sd);
    chk("c_store_byteenable", bus.c_store_byteenable, e_be);
    chk("busy", busy, e_busy);
    chk("owner", owner, e_owner);
    chk("timeout_err", terr, err_m);
    if (bus.c_done) begin
      if (exp_q.size() == 0) chk("scoreboard_nonempty", 0, 1);
      else begin
        done_t e;
        e = exp_q.pop_front();
        chk("f_done", bus.f_done, !e.port);
        chk("m_done", bus.m_done, e.port);
        chk("owner_response", e.port ? bus.m_response : bus.f_response, e.resp);
        chk("owner_load_data", e.port ? bus.m_load_data : bus.f_load_data, e.data);
        chk("other_response", e.port ? bus.f_response : bus.m_response, 0);
        if (contend) begin
          if (have_prev) chk("alternation", e.port, !prev_port);
          prev_port = e.port;
          have_prev = 1;
        end
      end
    end else begin
      chk("f_done_idle", bus.f_done, 0);
      chk("m_done_idle", bus.m_done, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cmd[0] = CACHE_CMD_EXECUTE; addr[0] = 32'h2000;
    cmd[1] = CACHE_CMD_NONE; addr[1] = 32'h0; sd = 32'h0; be = 4'h0;
    dir_v[0] = 0; dir_v[1] = 0;
    drive_ports();
    bus.c_done = 0; bus.c_response = 4'h0; bus.c_load_data = 32'h0;
    #1 rst_n = 0;
    @(posedge clk); #2;
    chk("rst_c_cmd", bus.c_cmd, CACHE_CMD_NONE);
    chk("rst_c_address", bus.c_address, 0);
    chk("rst_c_store_data", bus.c_store_data, 0);
    chk("rst_c_byteenable", bus.c_store_byteenable, 0);
    chk("rst_f_done", bus.f_done, 0);
    chk("rst_m_done", bus.m_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", terr, 0);
    chk("rst_owner", owner, 0);
    do_reset();
    // single fetch, done on the third busy cycle with fixed data
    fd_v = 1; fd_resp = CACHE_RESPONSE_DONE; fd_data = 32'h0000_0013; lat_fix = 2;
    dir_v[0] = 1; dir_cmd[0] = CACHE_CMD_EXECUTE; dir_addr[0] = 32'h2000;
    repeat (6) cycle();
    fd_v = 0;
    // tie straight after reset: fetch first, then execute
    do_reset();
    dir_v[0] = 1; dir_cmd[0] = CACHE_CMD_EXECUTE; dir_addr[0] = 32'h2000;
    dir_v[1] = 1; dir_cmd[1] = CACHE_CMD_LOAD; dir_addr[1] = 32'h8000;
    repeat (10) cycle();
    // continuous contention
    lat_fix = -1; lat_hi = 3; issue_pct = 100; contend = 1; have_prev = 0;
    repeat (40) cycle();
    contend = 0; issue_pct = 0;
    drain();
    // store pass-through
    lat_fix = 3;
    dir_v[1] = 1; dir_cmd[1] = CACHE_CMD_STORE; dir_addr[1] = 32'h100;
    dir_sd = 32'hDEAD_BEEF; dir_be = 4'b0011;
    repeat (8) cycle();
    // random traffic
    lat_fix = -1; lat_hi = 4; issue_pct = 60;
    repeat (2000) cycle();
    issue_pct = 0;
    drain();
    // withheld c_done trips the sticky timeout
    lat_fix = 12;
    dir_v[0] = 1; dir_cmd[0] = CACHE_CMD_EXECUTE; dir_addr[0] = 32'h3000;
    repeat (16) cycle();
    chk("timeout_sticky", terr, 1);
    lat_fix = 6;
    // reset while a command is outstanding
    issue_pct = 100;
    for (int i = 0; i < 20 && cur < 0; i++) cycle();
    chk("busy_before_reset", cur >= 0, 1);
    @(posedge clk); #3;
    checking = 0;
    rst_n = 0;
    #1;
    chk("async_rst_c_cmd", bus.c_cmd, CACHE_CMD_NONE);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_timeout", terr, 0);
    chk("async_rst_done", bus.f_done || bus.m_done, 0);
    issue_pct = 0; lat_fix = 2;
    do_reset();
    dir_v[0] = 1; dir_cmd[0] = CACHE_CMD_FLUSH_ALL; dir_addr[0] = 32'h4000;
    dir_v[1] = 1; dir_cmd[1] = CACHE_CMD_LOAD; dir_addr[1] = 32'h9000;
    repeat (10) cycle();
    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
